// File: rtl/reg_file_32x64.sv
// 32-entry architectural register file: two combinational read ports built from
// per-bit 32:1 mux trees, one synchronous write port, same-cycle write-to-read bypass.

module reg_file_32x64_mux32 (
    input  logic [31:0] col_i,
    input  logic [4:0]  sel_i,
    output logic        bit_o
);
    logic [15:0] l1;
    logic [7:0]  l2;
    logic [3:0]  l3;
    logic [1:0]  l4;

    // Five binary levels, LSB of the address selects first.
    generate
        for (genvar n = 0; n < 16; n++) begin : g_l1
            assign l1[n] = sel_i[0] ? col_i[2*n+1] : col_i[2*n];
        end
        for (genvar n = 0; n < 8; n++) begin : g_l2
            assign l2[n] = sel_i[1] ? l1[2*n+1] : l1[2*n];
        end
        for (genvar n = 0; n < 4; n++) begin : g_l3
            assign l3[n] = sel_i[2] ? l2[2*n+1] : l2[2*n];
        end
        for (genvar n = 0; n < 2; n++) begin : g_l4
            assign l4[n] = sel_i[3] ? l3[2*n+1] : l3[2*n];
        end
    endgenerate

    assign bit_o = sel_i[4] ? l4[1] : l4[0];
endmodule

module reg_file_32x64 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);
    localparam int         NUM_REGS = 32;
    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [NUM_REGS-1:0][WIDTH-1:0] entry;
    logic [WIDTH-1:0][NUM_REGS-1:0] bit_col;
    logic [WIDTH-1:0]               tree_a;
    logic [WIDTH-1:0]               tree_b;
    logic                           hit_a;
    logic                           hit_b;
    logic                           zero_a;
    logic                           zero_b;

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
            if (r == ZERO_REG) begin : g_zero
                assign entry[r] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] entry_q;
                logic [WIDTH-1:0] entry_d;
                logic             we;

                assign we      = wr_en && (wr_addr == 5'(r));
                assign entry_d = we ? wr_data : entry_q;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) entry_q <= '0;
                    else          entry_q <= entry_d;
                end

                assign entry[r] = entry_q;
            end
        end

        // Transpose so each data bit gets its own 32-wide column for a mux tree.
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
                assign bit_col[b][r] = entry[r][b];
            end

            reg_file_32x64_mux32 u_mux_a (
                .col_i (bit_col[b]),
                .sel_i (rd_addr_a),
                .bit_o (tree_a[b])
            );

            reg_file_32x64_mux32 u_mux_b (
                .col_i (bit_col[b]),
                .sel_i (rd_addr_b),
                .bit_o (tree_b[b])
            );
        end
    endgenerate

    assign hit_a  = wr_en && (wr_addr == rd_addr_a);
    assign hit_b  = wr_en && (wr_addr == rd_addr_b);
    assign zero_a = (rd_addr_a == ZERO_IDX);
    assign zero_b = (rd_addr_b == ZERO_IDX);

    // Zero register and reset override the bypass, which overrides storage.
    always_comb begin
        rd_data_a = tree_a;
        if (hit_a)              rd_data_a = wr_data;
        if (zero_a || !reset_n) rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = tree_b;
        if (hit_b)              rd_data_b = wr_data;
        if (zero_b || !reset_n) rd_data_b = '0;
    end
endmodule
